// File: rtl/clkmon_multi.sv
// Purpose: N-channel clock frequency monitor. Counts synchronised tst_clk edges per gate window,
//          range-checks each count, and flags channels that stop toggling.
// Latency: tst edge to counter 3 clk; meas/ok/meas_valid registered one cycle after window close.
// Backpressure: none; status outputs are free-running and meas_valid is a single-cycle strobe.
//
// Ports:
//   clk, rst_n            monitor clock, async active-low reset
//   enable                run the gate; low holds gate/edge/loss counters at zero
//   clr                   clears err_sticky (set in the same cycle wins)
//   tst_clk[N_CH]         monitored clocks, asynchronous to clk
//   cfg_min/cfg_max       per-channel count window, channel i at [i*CNT_W +: CNT_W]
//   meas                  last completed-window edge count per channel (saturating)
//   meas_valid            one-cycle pulse when meas/ok update
//   ok, lost, err_sticky  per-channel in-range, stuck, and latched-failure flags
module clkmon_multi #(
  parameter int N_CH     = 4,
  parameter int CLK_MHZ  = 100,
  parameter int GATE_US  = 10,
  parameter int CNT_W    = 16,
  parameter int LOSS_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clr,
  input  logic [N_CH-1:0]        tst_clk,
  input  logic [N_CH*CNT_W-1:0]  cfg_min,
  input  logic [N_CH*CNT_W-1:0]  cfg_max,
  output logic [N_CH*CNT_W-1:0]  meas,
  output logic                   meas_valid,
  output logic [N_CH-1:0]        ok,
  output logic [N_CH-1:0]        lost,
  output logic [N_CH-1:0]        err_sticky
);

  localparam int GATE_CYC = CLK_MHZ * GATE_US;
  localparam int GW       = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int LW       = $clog2(LOSS_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]             s1, s2, s3;
  logic [N_CH-1:0]             tedge;
  logic [GW-1:0]               gcnt;
  logic                        gate_end;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_sat;
  logic [N_CH-1:0][LW-1:0]     lcnt_q;
  logic [N_CH-1:0]             ok_next;
  logic [N_CH-1:0]             lost_rise;
  logic [N_CH-1:0]             err_set;

  // s1/s2 form the synchroniser; s3 is the delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= tst_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tedge    = s2 & ~s3;
  assign gate_end = enable && (gcnt == GW'(GATE_CYC - 1));

  always_comb begin
    cnt_sat   = '0;
    lost      = '0;
    ok_next   = '0;
    lost_rise = '0;
    err_set   = '0;
    for (int i = 0; i < N_CH; i++) begin
      // An edge landing in the gate_end cycle is folded into the closing window.
      cnt_sat[i]   = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(tedge[i]);
      lost[i]      = (lcnt_q[i] == LW'(LOSS_CYC));
      ok_next[i]   = (cnt_sat[i] >= cfg_min[i*CNT_W +: CNT_W]) &&
                     (cnt_sat[i] <= cfg_max[i*CNT_W +: CNT_W]) && !lost[i];
      // Loss counter is one step from saturating and no edge arrives to clear it.
      lost_rise[i] = enable && !tedge[i] && (lcnt_q[i] == LW'(LOSS_CYC - 1));
      err_set[i]   = (gate_end && !ok_next[i]) || lost_rise[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt       <= '0;
      cnt_q      <= '0;
      lcnt_q     <= '0;
      meas       <= '0;
      meas_valid <= 1'b0;
      ok         <= '0;
      err_sticky <= '0;
    end else begin
      meas_valid <= gate_end;
      err_sticky <= (clr ? '0 : err_sticky) | err_set;
      if (!enable) begin
        // Disabled: restart cleanly so the next window is a full GATE_CYC long.
        gcnt   <= '0;
        cnt_q  <= '0;
        lcnt_q <= '0;
        ok     <= '0;
      end else begin
        gcnt <= gate_end ? '0 : gcnt + GW'(1);
        for (int i = 0; i < N_CH; i++) begin
          cnt_q[i] <= gate_end ? '0 : cnt_sat[i];
          if (gate_end) begin
            meas[i*CNT_W +: CNT_W] <= cnt_sat[i];
          end
          if (tedge[i]) begin
            lcnt_q[i] <= '0;
          end else if (!lost[i]) begin
            lcnt_q[i] <= lcnt_q[i] + LW'(1);
          end
          // A window close re-evaluates ok; between closes, a lost channel drops ok.
          if (gate_end) begin
            ok[i] <= ok_next[i];
          end else if (lost[i]) begin
            ok[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clkmon_multi.sv
// Purpose: self-checking bench for clkmon_multi; reference model tracks tst samples per cycle.
// Latency: outputs compared every cycle on the falling edge against the model.
// Backpressure: none; stimulus is directed per scenario.
module tb_clkmon_multi;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int GATE = 1000;
  localparam int LOSS = 64;
  localparam int MAXC = 60000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  tst_clk = '0;
  logic [N*W-1:0] cfg_min, cfg_max;
  logic [N*W-1:0] meas;
  logic          meas_valid;
  logic [N-1:0]  ok, lost, err_sticky;

  logic [N*6-1:0] cfg6_min, cfg6_max, meas6;
  logic           meas_valid6;
  logic [N-1:0]   ok6, lost6, err6;

  int vectors = 0;
  int miscompares = 0;

  int freq[N] = '{25, 20, 10, 5};
  int acc[N]  = '{0, 0, 0, 0};
  int cmin[N] = '{248, 198, 98, 48};
  int cmax[N] = '{252, 202, 102, 52};

  clkmon_multi #(.N_CH(N), .CLK_MHZ(100), .GATE_US(10), .CNT_W(W), .LOSS_CYC(LOSS)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .tst_clk(tst_clk),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .meas(meas), .meas_valid(meas_valid),
    .ok(ok), .lost(lost), .err_sticky(err_sticky)
  );

  clkmon_multi #(.N_CH(N), .CLK_MHZ(100), .GATE_US(10), .CNT_W(6), .LOSS_CYC(LOSS)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .tst_clk(tst_clk),
    .cfg_min(cfg6_min), .cfg_max(cfg6_max), .meas(meas6), .meas_valid(meas_valid6),
    .ok(ok6), .lost(lost6), .err_sticky(err6)
  );

  always #5 clk = ~clk;

  assign cfg6_min = '0;
  assign cfg6_max = {4{6'd62}};

  always_comb begin
    cfg_min = '0;
    cfg_max = '0;
    for (int i = 0; i < N; i++) begin
      cfg_min[i*W +: W] = W'(cmin[i]);
      cfg_max[i*W +: W] = W'(cmax[i]);
    end
  end

  // Test clocks in MHz: phase accumulator in units of 1/100 of a clk period; one rise per wrap.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (freq[i] == 0) begin
        tst_clk[i] = 1'b0;
      end else begin
        acc[i] = (acc[i] + freq[i]) % 100;
        tst_clk[i] = (acc[i] < 50);
      end
    end
  end

  // ---------------- reference model ----------------
  bit        samp [N][MAXC];
  int        cyc = 0;
  int        rb = 0;
  int        ws = 0;
  bit        en_run = 1'b0;
  int        last_edge[N] = '{0, 0, 0, 0};
  logic [N-1:0]  m_ok = '0, m_lost = '0, m_err = '0;
  logic [W-1:0]  m_meas[N] = '{0, 0, 0, 0};
  logic          m_mv = 1'b0;

  // Edge counted at cycle m: tst sampled high at m-2 and low at m-3 (samples before reset release read as 0).
  function automatic bit edge_at(int ch, int m);
    bit a, b;
    a = (m - 2 >= rb) ? samp[ch][m-2] : 1'b0;
    b = (m - 3 >= rb) ? samp[ch][m-3] : 1'b0;
    return a & ~b;
  endfunction

  always @(posedge clk) begin
    bit set_b[N];
    bit close, nl, okn;
    int n;
    for (int i = 0; i < N; i++) set_b[i] = 1'b0;
    if (!rst_n) begin
      rb = cyc + 1;
      en_run = 1'b0;
      m_mv = 1'b0;
      m_ok = '0;
      m_lost = '0;
      m_err = '0;
      for (int i = 0; i < N; i++) m_meas[i] = '0;
    end else begin
      if (cyc < MAXC) for (int i = 0; i < N; i++) samp[i][cyc] = tst_clk[i];
      if (!enable) begin
        en_run = 1'b0;
        m_mv = 1'b0;
        m_ok = '0;
        m_lost = '0;
      end else begin
        if (!en_run) begin
          en_run = 1'b1;
          ws = cyc;
          for (int i = 0; i < N; i++) last_edge[i] = cyc - 1;
        end
        close = ((cyc - ws) % GATE) == GATE - 1;
        for (int i = 0; i < N; i++) begin
          if (edge_at(i, cyc)) last_edge[i] = cyc;
          nl = (cyc - last_edge[i]) >= LOSS;
          if (close) begin
            n = 0;
            for (int j = cyc - GATE + 1; j <= cyc; j++) n += int'(edge_at(i, j));
            if (n > 65535) n = 65535;
            m_meas[i] = W'(n);
            okn = (n >= cmin[i]) && (n <= cmax[i]) && !m_lost[i];
            m_ok[i] = okn;
            set_b[i] = !okn;
          end else if (m_lost[i]) begin
            m_ok[i] = 1'b0;
          end
          if (nl && !m_lost[i]) set_b[i] = 1'b1;
          m_lost[i] = nl;
        end
        m_mv = close;
      end
      for (int i = 0; i < N; i++) begin
        if (set_b[i]) m_err[i] = 1'b1;
        else if (clr) m_err[i] = 1'b0;
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N*W-1:0] em;
    em = '0;
    for (int i = 0; i < N; i++) em[i*W +: W] = m_meas[i];
    vectors++;
    if ({meas, meas_valid, ok, lost, err_sticky} !== {em, m_mv, m_ok, m_lost, m_err}) begin
      miscompares++;
      $display("FAIL model_cycle t=%0t: got meas=%h mv=%b ok=%b lost=%b err=%b, want meas=%h mv=%b ok=%b lost=%b err=%b",
               $time, meas, meas_valid, ok, lost, err_sticky, em, m_mv, m_ok, m_lost, m_err);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic wait_mv(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!meas_valid && waited < 1200);
    if (!meas_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_mv: no meas_valid within %0d cycles", waited);
    end
  endtask

  localparam logic [63:0] NOMINAL = {16'd50, 16'd100, 16'd200, 16'd250};

  initial begin
    int w;
    int n;
    tick(3);
    check("reset_outputs", {meas, meas_valid, ok, lost, err_sticky}, 64'd0);

    // Scenario 1: nominal clocks
    rst_n = 1'b1;
    enable = 1'b1;
    wait_mv(w);
    wait_mv(w);
    check("s1_meas_win2", meas, NOMINAL);
    check("s1_ok_win2", ok, 4'hF);
    check("s1_cntw6_saturated_meas", meas6, {6'd50, 6'd63, 6'd63, 6'd63});
    check("s1_cntw6_ok", ok6, 4'b1000);
    wait_mv(w);
    check("s1_mv_period", w, 1000);

    // Scenario 2: ch2 stuck low
    freq[2] = 0;
    n = 0;
    while (!lost[2] && n < 200) begin
      tick(1);
      n++;
    end
    check("s2_lost_within_67_of_last_edge", (n <= 77), 1);
    tick(1);
    check("s2_ok_after_lost", ok, 4'b1011);
    check("s2_lost", lost, 4'b0100);
    check("s2_err", err_sticky, 4'b0100);
    freq[2] = 10;

    // Scenario 3: ch1 off-frequency, then recovery and clr
    freq[1] = 22;
    wait_mv(w);
    wait_mv(w);
    check("s3_meas1_22mhz", meas[31:16], 16'd220);
    check("s3_ok1_low", ok[1], 1'b0);
    check("s3_err1_set", err_sticky[1], 1'b1);
    freq[1] = 20;
    wait_mv(w);
    wait_mv(w);
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("s3_err_cleared", err_sticky, 4'b0000);

    // Scenario 4: clr coinciding with a failing window close
    freq[3] = 7;
    wait_mv(w);
    wait_mv(w);
    check("s4_err3_before", err_sticky, 4'b1000);
    tick(999);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("s4_close_aligned", meas_valid, 1'b1);
    check("s4_meas3_70", meas[63:48], 16'd70);
    check("s4_set_wins_over_clr", err_sticky, 4'b1000);
    freq[3] = 5;
    wait_mv(w);
    wait_mv(w);
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;

    // Scenario 5: enable dropped mid-window
    wait_mv(w);
    tick(400);
    enable = 1'b0;
    n = 0;
    repeat (300) begin
      tick(1);
      if (meas_valid) n++;
    end
    check("s5_no_mv_while_disabled", n, 0);
    check("s5_ok_lost_zero", {ok, lost}, 8'd0);
    enable = 1'b1;
    wait_mv(w);
    check("s5_first_mv_full_window", (w >= 1000 && w <= 1001), 1);
    check("s5_meas_full_counts", meas, NOMINAL);
    check("s5_ok", ok, 4'hF);

    // Scenario 6: async reset mid-window
    wait_mv(w);
    tick(500);
    #2 rst_n = 1'b0;
    #1 check("s6_reset_immediate", {meas, meas_valid, ok, lost, err_sticky}, 64'd0);
    tick(3);
    rst_n = 1'b1;
    wait_mv(w);
    wait_mv(w);
    check("s6_meas_after_reset", meas, NOMINAL);
    check("s6_ok_after_reset", ok, 4'hF);
    check("s6_err_after_reset", err_sticky, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
